// File: rtl/lab2_proc_pkg.sv
// Shared lab2 processor definitions: immediate-type codes, RV32 opcodes and
// the instruction buffer entry layout. Used by the instruction buffer, the
// immediate generator and the control unit.
package lab2_proc_pkg;

    // imm_type encoding shared with the immediate generator
    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_B  = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;
    localparam logic [2:0] IMM_IV = 3'd5;
    localparam logic [2:0] IMM_X  = 3'd7;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 of the shift-immediate forms (slli / srli / srai)
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    // One buffered fetch result
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ib_entry_t;

endpackage

// File: rtl/lab2_proc_imm_type_decode.sv
// Combinational pre-decode of the immediate format of an RV32 instruction.
// Output codes 0-5 feed the immediate generator directly; 7 means no immediate.
module lab2_proc_imm_type_decode
    import lab2_proc_pkg::*;
(
    input  logic [31:0] inst,
    output logic [2:0]  imm_type
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign unused_bits = ^{inst[31:15], inst[11:7]};

    // Opcode (and funct3 for shift-immediates) to immediate format
    always_comb begin
        imm_type = IMM_X;
        case (opcode)
            OPC_LOAD, OPC_JALR: imm_type = IMM_I;
            OPC_OP_IMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) imm_type = IMM_IV;
                else                                         imm_type = IMM_I;
            end
            OPC_STORE:           imm_type = IMM_S;
            OPC_BRANCH:          imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:  imm_type = IMM_U;
            OPC_JAL:             imm_type = IMM_J;
            default:             imm_type = IMM_X;
        endcase
    end

endmodule

// File: rtl/lab2_proc_inst_buf.sv
// Instruction buffer between the imem response and decode. Circular FIFO of
// {inst, pc} with a drop counter that discards responses still in flight when
// a flush/redirect happens. The head is presented with its pre-decoded
// imm_type.
// Optional: define LAB2_PROC_INST_BUF_BYPASS_EN for a 0-cycle path from enq to
// deq when the buffer is empty and not discarding.
module lab2_proc_inst_buf
    import lab2_proc_pkg::*;
#(
    parameter int unsigned p_depth  = 2,
    parameter int unsigned p_drop_w = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_val,
    output logic                      enq_rdy,
    input  logic [31:0]               enq_inst,
    input  logic [31:0]               enq_pc,
    input  logic                      flush,
    input  logic [p_drop_w-1:0]       flush_drop,
    output logic                      deq_val,
    input  logic                      deq_rdy,
    output logic [31:0]               deq_inst,
    output logic [31:0]               deq_pc,
    output logic [2:0]                deq_imm_type,
    output logic [$clog2(p_depth):0]  count
);

    localparam int unsigned ptr_w = $clog2(p_depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(p_depth);

    ib_entry_t            mem_q [p_depth];
    ib_entry_t            head_entry;
    logic [ptr_w-1:0]     head_q, head_d;
    logic [ptr_w-1:0]     tail_q, tail_d;
    logic [cnt_w-1:0]     count_q, count_d;
    logic [p_drop_w-1:0]  drop_q, drop_d;

    logic dropping;
    logic buf_val;
    logic enq_fire;
    logic deq_fire;
    logic bypass;
    logic wr_en;

    assign dropping   = (drop_q != '0);
    assign head_entry = mem_q[head_q];

    // While discarding, enq stays ready so stale responses drain at full rate
    assign enq_rdy  = (count_q < depth_c) || dropping;
    assign enq_fire = enq_val && enq_rdy;
    assign buf_val  = (count_q != '0) && !flush;
    assign deq_fire = buf_val && deq_rdy;

`ifdef LAB2_PROC_INST_BUF_BYPASS_EN
    assign bypass = (count_q == '0) && !dropping && !flush && enq_val;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry consumed this cycle is never written
    assign wr_en = enq_fire && !dropping && !flush && !(bypass && deq_rdy);

    // Head presentation, sourced from enq on the bypass path
    always_comb begin
        deq_val  = buf_val || bypass;
        deq_inst = head_entry.inst;
        deq_pc   = head_entry.pc;
        if (bypass) begin
            deq_inst = enq_inst;
            deq_pc   = enq_pc;
        end
    end

    lab2_proc_imm_type_decode u_imm_type_decode (
        .inst     (deq_inst),
        .imm_type (deq_imm_type)
    );

    assign count = count_q;

    // Next-state for pointers, occupancy and drop counter
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (flush) begin
            // Flush-cycle enq is discarded without touching the new drop value
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            drop_d  = flush_drop;
        end else begin
            if (enq_fire && dropping) drop_d = drop_q - p_drop_w'(1);
            if (deq_fire)             head_d = head_q + ptr_w'(1);
            if (wr_en)                tail_d = tail_q + ptr_w'(1);
            case ({wr_en, deq_fire})
                2'b10:   count_d = count_q + cnt_w'(1);
                2'b01:   count_d = count_q - cnt_w'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[tail_q] <= '{inst: enq_inst, pc: enq_pc};
        end
    end

endmodule

// File: tb/tb_lab2_proc_inst_buf.sv
// Self-checking bench for lab2_proc_inst_buf: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_lab2_proc_inst_buf;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DROPW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_val;
    logic        enq_rdy;
    logic [31:0] enq_inst;
    logic [31:0] enq_pc;
    logic        flush;
    logic [1:0]  flush_drop;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [2:0]  deq_imm_type;
    logic [1:0]  count;

    always #5 clk = ~clk;

    lab2_proc_inst_buf #(
        .p_depth  (DEPTH),
        .p_drop_w (DROPW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_val      (enq_val),
        .enq_rdy      (enq_rdy),
        .enq_inst     (enq_inst),
        .enq_pc       (enq_pc),
        .flush        (flush),
        .flush_drop   (flush_drop),
        .deq_val      (deq_val),
        .deq_rdy      (deq_rdy),
        .deq_inst     (deq_inst),
        .deq_pc       (deq_pc),
        .deq_imm_type (deq_imm_type),
        .count        (count)
    );

    // Reference model: FIFO contents as {inst, pc} and pending discards
    logic [63:0] mq[$];
    int unsigned mdrop;
    bit          known;
    int          tests;
    int          fails;

    function automatic logic [2:0] ref_imm(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        case (i[6:0])
            7'b0000011, 7'b1100111: return 3'd0;
            7'b0010011:             return (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0;
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance model
    task automatic step(input bit r, input bit ev, input logic [31:0] ei, input logic [31:0] ep,
                        input bit fl, input logic [1:0] fd, input bit dr);
        bit          byp;
        bit          exp_dv;
        bit          exp_er;
        logic [63:0] head;
        reset = r; enq_val = ev; enq_inst = ei; enq_pc = ep;
        flush = fl; flush_drop = fd; deq_rdy = dr;
        #2;
        byp    = 1'b0;
        exp_dv = 1'b0;
        exp_er = 1'b0;
`ifdef LAB2_PROC_INST_BUF_BYPASS_EN
        byp = known && mq.size() == 0 && mdrop == 0 && !fl && ev;
`endif
        if (known) begin
            exp_er = (mq.size() < DEPTH) || (mdrop != 0);
            exp_dv = (mq.size() != 0 && !fl) || byp;
            check("enq_rdy", 32'(enq_rdy), 32'(exp_er));
            check("deq_val", 32'(deq_val), 32'(exp_dv));
            check("count", 32'(count), mq.size());
            if (exp_dv) begin
                head = byp ? {ei, ep} : mq[0];
                check("deq_inst", deq_inst, head[63:32]);
                check("deq_pc", deq_pc, head[31:0]);
                check("deq_imm_type", 32'(deq_imm_type), 32'(ref_imm(head[63:32])));
            end
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            mdrop = 0;
            known = 1'b1;
        end else if (known) begin
            if (fl) begin
                mq.delete();
                mdrop = fd;
            end else begin
                if (exp_dv && dr && !byp) void'(mq.pop_front());
                if (ev && exp_er) begin
                    if (mdrop != 0)       mdrop--;
                    else if (!(byp && dr)) mq.push_back({ei, ep});
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit dr);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, dr);
    endtask

    task automatic enq(input logic [31:0] ei, input logic [31:0] ep, input bit dr);
        step(1'b0, 1'b1, ei, ep, 1'b0, 2'd0, dr);
    endtask

    logic [31:0] tbl_inst [6];
    logic [2:0]  tbl_imm  [6];
    logic [31:0] ri;
    bit          rr, rf, rv, rd;

    initial begin
        tests = 0;
        fails = 0;
        known = 1'b0;
        mdrop = 0;
        tbl_inst[0] = 32'h00209663; tbl_imm[0] = 3'd2;
        tbl_inst[1] = 32'h0000006F; tbl_imm[1] = 3'd4;
        tbl_inst[2] = 32'h12345037; tbl_imm[2] = 3'd3;
        tbl_inst[3] = 32'h00311093; tbl_imm[3] = 3'd5;
        tbl_inst[4] = 32'h00112023; tbl_imm[4] = 3'd1;
        tbl_inst[5] = 32'h002081B3; tbl_imm[5] = 3'd7;

        // Reset and reset state
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        idle(1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_val", 32'(deq_val), 32'd0);
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);

        // addi x1,x0,5 through the buffer
        enq(32'h00500093, 32'h200, 1'b1);
        idle(1'b1);
        check("addi_count", 32'(count), 32'd0);

        // Fill past capacity, then drain across the pointer wrap
        enq(32'h00000013, 32'h10, 1'b0);
        enq(32'h00000013, 32'h14, 1'b0);
        enq(32'h00000013, 32'h18, 1'b0);
        check("full_count", 32'(count), 32'd2);
        check("full_enq_rdy", 32'(enq_rdy), 32'd0);
        idle(1'b1);
        enq(32'h00100013, 32'h20, 1'b1);
        enq(32'h00200013, 32'h24, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Pre-decoded imm types
        for (int i = 0; i < 6; i++) begin
            enq(tbl_inst[i], 32'h40 + 32'(i * 4), 1'b0);
            check("tbl_imm_type", 32'(deq_imm_type), 32'(tbl_imm[i]));
            idle(1'b1);
        end

        // Flush with two entries held, drop two, flush-cycle enq discarded
        enq(32'h00000013, 32'h100, 1'b0);
        enq(32'h00000013, 32'h104, 1'b0);
        step(1'b0, 1'b1, 32'h00000013, 32'h1F0, 1'b1, 2'd2, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        enq(32'h00000013, 32'h280, 1'b0);
        enq(32'h00000013, 32'h284, 1'b0);
        enq(32'h00000013, 32'h300, 1'b0);
        check("post_drop_val", 32'(deq_val), 32'd1);
        check("post_drop_pc", deq_pc, 32'h300);
        check("post_drop_count", 32'(count), 32'd1);
        idle(1'b1);

        // Second flush replaces residual drop count
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
        enq(32'h00000013, 32'h400, 1'b0);
        enq(32'h00000013, 32'h404, 1'b0);
        check("reflush_pc", deq_pc, 32'h404);
        check("reflush_count", 32'(count), 32'd1);
        idle(1'b1);

        // Reset mid-drain clears contents and pending drops
        enq(32'h00000013, 32'h500, 1'b0);
        enq(32'h00000013, 32'h504, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_deq_val", 32'(deq_val), 32'd0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        enq(32'h00000013, 32'h508, 1'b0);
        check("rst_clears_drop_pc", deq_pc, 32'h508);
        idle(1'b1);

`ifdef LAB2_PROC_INST_BUF_BYPASS_EN
        // Same-cycle bypass into an empty buffer
        enq(32'h00500093, 32'h600, 1'b1);
        check("bypass_count", 32'(count), 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            ri = $urandom;
            case ($urandom_range(0, 11))
                0: ri[6:0] = 7'b0000011;
                1: ri[6:0] = 7'b1100111;
                2: ri[6:0] = 7'b0010011;
                3: ri[6:0] = 7'b0100011;
                4: ri[6:0] = 7'b1100011;
                5: ri[6:0] = 7'b0110111;
                6: ri[6:0] = 7'b0010111;
                7: ri[6:0] = 7'b1101111;
                8: ri[6:0] = 7'b0110011;
                default: ;
            endcase
            rr = ($urandom_range(0, 99) == 0);
            rf = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 1) == 1);
            step(rr, rv, ri, $urandom, rf, 2'($urandom_range(0, 3)), rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lab2_proc_inst_buf.md
Name: lab2_proc_inst_buf

Overview:
- Instruction buffer between imem response and the decode (D) stage.
- Holds up to p_depth fetched {inst, pc} pairs in a circular FIFO.
- Discards stale in-flight responses after a redirect/squash.
- Presents the head instruction to D with its pre-decoded imm_type, which drives the immediate generator directly, so decode does not re-derive it.

Parameters:
- p_depth, 2, number of entries; power of two, >= 2.
- p_drop_w, 2, width of the in-flight drop counter; up to 2^p_drop_w - 1 discards.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- enq_val  input  1  imem response valid.
- enq_rdy  output  1  buffer accepts an enq this cycle.
- enq_inst  input  32  fetched instruction.
- enq_pc  input  32  PC of the fetched instruction.
- flush  input  1  squash: clear contents, start discarding in-flight responses.
- flush_drop  input  p_drop_w  number of already-issued responses to discard after flush.
- deq_val  output  1  head entry valid.
- deq_rdy  input  1  D stage consumes the head.
- deq_inst  output  32  head instruction.
- deq_pc  output  32  head PC.
- deq_imm_type  output  3  imm type of head, encoded as below.
- count  output  $clog2(p_depth)+1  occupancy, for debug/perf counters.

Behaviour:
- Reset: count=0, drop counter=0, head/tail pointers=0, deq_val=0, enq_rdy=1. Data registers are not reset; deq_inst/deq_pc are don't-care while deq_val=0.
- Handshakes:
  - Fire occurs when val && rdy, sampled at the rising edge.
  - enq_rdy = (count < p_depth) || (drop != 0). There is no same-cycle pass-through when full.
  - deq_val = (count != 0) && !flush.
- Latency: an accepted enq is visible on deq the next cycle (1-cycle minimum).
- Simultaneous enq and deq fire when not full: count is unchanged and pointers advance independently. Pointers wrap mod p_depth.
- Drop counter:
  - When drop != 0, an enq fire is discarded (not written) and drop decrements by 1.
  - While drop != 0, deq side is unaffected: entries already buffered before the flush are gone anyway.
- Flush, in cycle t:
  - At edge t+1: count=0 and pointers=0.
  - drop is loaded with flush_drop. It replaces any residual value; it is not accumulated.
  - An enq fire in cycle t is discarded and does not decrement the new drop value.
  - deq_val is forced 0 in cycle t, so no deq fire occurs.
- flush and reset together: reset wins.
- deq_imm_type is combinational from deq_inst[6:0] (and funct3 for shifts):
  - 0 (I): opcodes 0000011, 1100111, and 0010011 with funct3 not in {001,101}.
  - 5 (I-variant, shamt): opcode 0010011 with funct3 in {001,101}.
  - 1 (S): opcode 0100011.
  - 2 (B): opcode 1100011.
  - 3 (U): opcodes 0110111, 0010111.
  - 4 (J): opcode 1101111.
  - 7: all other opcodes (R-type, illegal). D must not use the immediate in this case.
- Codes 0-5 match the immediate generator's imm_type encoding exactly.

Optional Feature:
- Macro: LAB2_PROC_INST_BUF_BYPASS_EN.
- Defined:
  - When count==0, drop==0, !flush and enq_val, deq_val=1 in the same cycle.
  - deq_inst/deq_pc/deq_imm_type are sourced from enq_* in that case.
  - If deq_rdy, the entry is consumed without being written and count stays 0 (0-cycle latency).
  - enq_rdy is unchanged.
- Undefined: 1-cycle minimum latency as above.

Decomposition:
- Shared header lab2_proc_pkg. Holds:
  - imm_type localparams: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_IV=5, IMM_X=7.
  - RV32 opcode constants.
- The immediate generator and the control unit also use this header.
- One combinational sub-module, lab2_proc_imm_type_decode: inst[31:0] -> imm_type[2:0]. It is also usable by the control unit.

Test Plan:
- Reset, then enq 0x00500093 (addi x1,x0,5), pc 0x200, deq_rdy=1 -> deq_val=1 next cycle; deq_imm_type=0; deq_pc=0x200; count returns to 0.
- Enq 3 back-to-back with deq_rdy=0, p_depth=2 -> enq_rdy=0 after 2 fires; count=2. Then deq_rdy=1 -> insts pop in order and pointers wrap correctly.
- Enq 0x00209663 (bne), 0x0000006F (jal), 0x12345037 (lui), 0x00311093 (slli), 0x00112023 (sw), 0x002081B3 (add) -> deq_imm_type 2, 4, 3, 5, 1, 7.
- Buffer holds 2 entries; flush=1 with flush_drop=2 and a simultaneous enq:
  - count=0 next cycle.
  - The flush-cycle enq is dropped.
  - The next 2 enq fires are dropped.
  - The 3rd enq (pc 0x300) appears on deq.
- Flush with flush_drop=1 while drop=2 -> exactly one further enq is dropped.
- Reset asserted mid-drain with count=2, drop=1 -> count=0, drop=0, deq_val=0 next cycle.
- With BYPASS_EN: enq into empty buffer with deq_rdy=1 -> deq_val same cycle; count stays 0.
